// File: rtl/alu_ctrl_ri_beq_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_ri_beq_datapath_if
//  Description : Bundle of the execute-stage control/operand inputs and the
//                ALU / register-read / next-PC outputs. The master side is the
//                upstream control/fetch logic; the slave side is the datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_ctrl_ri_beq_datapath_if #(
    parameter int XLEN = 64
);
    // Upstream control and operand selection
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            alu_src;
    logic            reg_write;
    logic            branch;
    logic [11:0]     imm;
    logic [XLEN-1:0] pc;

    // Datapath results
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] read_data_1;
    logic [XLEN-1:0] read_data_2;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            overflow;
    logic [XLEN-1:0] next_pc;

    modport master (
        output alu_op, funct3, funct7, rs1, rs2, rd,
        output alu_src, reg_write, branch, imm, pc,
        input  alu_ctrl, read_data_1, read_data_2, alu_result,
        input  zero, overflow, next_pc
    );

    modport slave (
        input  alu_op, funct3, funct7, rs1, rs2, rd,
        input  alu_src, reg_write, branch, imm, pc,
        output alu_ctrl, read_data_1, read_data_2, alu_result,
        output zero, overflow, next_pc
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_ri_beq_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_ri_beq_datapath
//  Description : Execute-stage slice of the RV64 core: ALU control decode,
//                32 x XLEN register file, ALU with zero/overflow flags,
//                immediate sign-extension and beq next-PC selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_ri_beq_datapath #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    alu_ctrl_ri_beq_datapath_if.slave bus
);

    // ALU operation encodings
    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_sub = 4'b0110;
    localparam logic [3:0] c_op_slt = 4'b0111;
    localparam logic [3:0] c_op_nor = 4'b1100;

    // Main-control alu_op classes
    localparam logic [1:0] c_aluop_mem    = 2'b00;
    localparam logic [1:0] c_aluop_branch = 2'b01;
    localparam logic [1:0] c_aluop_rtype  = 2'b10;
    localparam logic [1:0] c_aluop_itype  = 2'b11;

    localparam logic [6:0] c_funct7_sub = 7'b0100000;

    logic [XLEN-1:0] r_regs [NREGS];

    logic [3:0]      w_alu_ctrl;
    logic [XLEN-1:0] w_read_data_1;
    logic [XLEN-1:0] w_read_data_2;
    logic [XLEN-1:0] w_sext_imm;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_slt;
    logic [XLEN-1:0] w_alu_result;
    logic            w_overflow;
    logic            w_zero;
    logic            w_taken;
    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] w_seq_pc;

    // Decode alu_op/funct3/funct7 into the ALU operation; I-type ignores funct7
    // so that funct3 000 is always addi.
    always_comb begin
        w_alu_ctrl = c_op_add;
        case (bus.alu_op)
            c_aluop_mem:    w_alu_ctrl = c_op_add;
            c_aluop_branch: w_alu_ctrl = c_op_sub;
            c_aluop_rtype, c_aluop_itype: begin
                case (bus.funct3)
                    3'b000: begin
                        if (bus.alu_op == c_aluop_rtype && bus.funct7 == c_funct7_sub)
                            w_alu_ctrl = c_op_sub;
                        else
                            w_alu_ctrl = c_op_add;
                    end
                    3'b111:  w_alu_ctrl = c_op_and;
                    3'b110:  w_alu_ctrl = c_op_or;
                    3'b010:  w_alu_ctrl = c_op_slt;
                    default: w_alu_ctrl = c_op_add;
                endcase
            end
            default: w_alu_ctrl = c_op_add;
        endcase
    end

    // Combinational register reads; x0 is forced to zero independent of storage.
    assign w_read_data_1 = (bus.rs1 == 5'd0) ? '0 : r_regs[bus.rs1];
    assign w_read_data_2 = (bus.rs2 == 5'd0) ? '0 : r_regs[bus.rs2];

    // Operand selection and immediate sign-extension from bit 11
    assign w_sext_imm = {{(XLEN-12){bus.imm[11]}}, bus.imm};
    assign w_op_a     = w_read_data_1;
    assign w_op_b     = bus.alu_src ? w_sext_imm : w_read_data_2;

    assign w_sum  = w_op_a + w_op_b;
    assign w_diff = w_op_a - w_op_b;
    assign w_slt  = ($signed(w_op_a) < $signed(w_op_b));

    // ALU result and signed-overflow flag; overflow only meaningful for add/sub.
    always_comb begin
        w_alu_result = '0;
        w_overflow   = 1'b0;
        case (w_alu_ctrl)
            c_op_and: w_alu_result = w_op_a & w_op_b;
            c_op_or:  w_alu_result = w_op_a | w_op_b;
            c_op_add: begin
                w_alu_result = w_sum;
                w_overflow   = (w_op_a[XLEN-1] == w_op_b[XLEN-1]) &&
                               (w_sum[XLEN-1]  != w_op_a[XLEN-1]);
            end
            c_op_sub: begin
                w_alu_result = w_diff;
                w_overflow   = (w_op_a[XLEN-1] != w_op_b[XLEN-1]) &&
                               (w_diff[XLEN-1] != w_op_a[XLEN-1]);
            end
            c_op_slt: w_alu_result = {{(XLEN-1){1'b0}}, w_slt};
            c_op_nor: w_alu_result = ~(w_op_a | w_op_b);
            default:  w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    // beq target is PC-relative in half-words; wraps modulo 2^XLEN.
    assign w_taken         = bus.branch & w_zero;
    assign w_branch_target = bus.pc + (w_sext_imm << 1);
    assign w_seq_pc        = bus.pc + XLEN'(4);

    // Register file: async reset seeds x[i] = i; reset wins over a pending write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= XLEN'(i);
            end
        end else if (bus.reg_write && bus.rd != 5'd0) begin
            r_regs[bus.rd] <= w_alu_result;
        end
    end

    assign bus.alu_ctrl    = w_alu_ctrl;
    assign bus.read_data_1 = w_read_data_1;
    assign bus.read_data_2 = w_read_data_2;
    assign bus.alu_result  = w_alu_result;
    assign bus.zero        = w_zero;
    assign bus.overflow    = w_overflow;
    assign bus.next_pc     = w_taken ? w_branch_target : w_seq_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_ri_beq_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_ri_beq_datapath
//  Description : Directed self-checking bench for alu_ctrl_ri_beq_datapath.
//                Expected values are queued when a step is driven and popped
//                when the combinational outputs are sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_ri_beq_datapath;

    localparam int XLEN = 64;

    logic clock;
    logic reset;

    alu_ctrl_ri_beq_datapath_if #(.XLEN(XLEN)) bus ();

    alu_ctrl_ri_beq_datapath #(.XLEN(XLEN), .NREGS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string           tag;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Queue one expected value
    task automatic push_exp(input string tag, input logic [XLEN-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against an observed value
    task automatic pop_cmp(input logic [XLEN-1:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive the operand/control fields of one instruction
    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] s1, input logic [4:0] s2, input logic src,
                         input logic [11:0] im, input logic br, input logic [XLEN-1:0] p);
        bus.alu_op  = op;
        bus.funct3  = f3;
        bus.funct7  = f7;
        bus.rs1     = s1;
        bus.rs2     = s2;
        bus.alu_src = src;
        bus.imm     = im;
        bus.branch  = br;
        bus.pc      = p;
    endtask

    // Queue all seven outputs, let them settle, then compare in order
    task automatic check_step(input string name,
                              input logic [XLEN-1:0] e_rd1, input logic [XLEN-1:0] e_rd2,
                              input logic [3:0] e_ctrl, input logic [XLEN-1:0] e_res,
                              input logic e_zero, input logic e_ovf,
                              input logic [XLEN-1:0] e_npc);
        push_exp({name, ".read_data_1"}, e_rd1);
        push_exp({name, ".read_data_2"}, e_rd2);
        push_exp({name, ".alu_ctrl"},    XLEN'(e_ctrl));
        push_exp({name, ".alu_result"},  e_res);
        push_exp({name, ".zero"},        XLEN'(e_zero));
        push_exp({name, ".overflow"},    XLEN'(e_ovf));
        push_exp({name, ".next_pc"},     e_npc);
        #1;
        pop_cmp(bus.read_data_1);
        pop_cmp(bus.read_data_2);
        pop_cmp(XLEN'(bus.alu_ctrl));
        pop_cmp(bus.alu_result);
        pop_cmp(XLEN'(bus.zero));
        pop_cmp(XLEN'(bus.overflow));
        pop_cmp(bus.next_pc);
    endtask

    // One register write: set up at negedge, commit on the following posedge
    task automatic do_write(input logic [4:0] dst, input logic [1:0] op,
                            input logic [4:0] s1, input logic [4:0] s2);
        @(negedge clock);
        drive(op, 3'b000, 7'b0000000, s1, s2, 1'b0, 12'h000, 1'b0, '0);
        bus.rd        = dst;
        bus.reg_write = 1'b1;
        @(posedge clock);
        #1;
        bus.reg_write = 1'b0;
    endtask

    localparam logic [XLEN-1:0] c_max_pos = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [XLEN-1:0] c_min_neg = 64'h8000_0000_0000_0000;

    initial begin
        reset         = 1'b1;
        bus.rd        = 5'd0;
        bus.reg_write = 1'b0;
        drive(2'b10, 3'b000, 7'b0000000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        #12;
        reset = 1'b0;

        // R-type decode and ALU functions on x3=3, x5=5
        check_step("rtype_add", 3, 5, 4'b0010, 8, 1'b0, 1'b0, 4);
        drive(2'b10, 3'b000, 7'b0100000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("rtype_sub", 3, 5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4);
        drive(2'b10, 3'b111, 7'b0000000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("rtype_and", 3, 5, 4'b0000, 1, 1'b0, 1'b0, 4);
        drive(2'b10, 3'b110, 7'b0000000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("rtype_or", 3, 5, 4'b0001, 7, 1'b0, 1'b0, 4);
        drive(2'b10, 3'b010, 7'b0000000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("rtype_slt", 3, 5, 4'b0111, 1, 1'b0, 1'b0, 4);
        drive(2'b10, 3'b001, 7'b0000000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("rtype_other_f3", 3, 5, 4'b0010, 8, 1'b0, 1'b0, 4);
        drive(2'b00, 3'b111, 7'b0100000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("ldst_add", 3, 5, 4'b0010, 8, 1'b0, 1'b0, 4);
        drive(2'b11, 3'b000, 7'b0100000, 5'd3, 5'd5, 1'b0, 12'h000, 1'b0, '0);
        check_step("itype_f7_ignored", 3, 5, 4'b0010, 8, 1'b0, 1'b0, 4);
        drive(2'b11, 3'b010, 7'b0000000, 5'd5, 5'd3, 1'b0, 12'h000, 1'b0, '0);
        check_step("slt_false", 5, 3, 4'b0111, 0, 1'b1, 1'b0, 4);

        // Register writes: x7 = x3 + x5, then a discarded write to x0
        do_write(5'd7, 2'b10, 5'd3, 5'd5);
        @(negedge clock);
        drive(2'b10, 3'b000, 7'b0000000, 5'd7, 5'd0, 1'b0, 12'h000, 1'b0, '0);
        check_step("x7_written", 8, 0, 4'b0010, 8, 1'b0, 1'b0, 4);
        do_write(5'd0, 2'b10, 5'd3, 5'd5);
        @(negedge clock);
        drive(2'b10, 3'b000, 7'b0000000, 5'd0, 5'd7, 1'b0, 12'h000, 1'b0, '0);
        check_step("x0_discard", 0, 8, 4'b0010, 8, 1'b0, 1'b0, 4);

        // Asynchronous reset between clock edges restores x7 = 7
        @(negedge clock);
        #2;
        reset = 1'b1;
        drive(2'b10, 3'b000, 7'b0000000, 5'd7, 5'd0, 1'b0, 12'h000, 1'b0, '0);
        check_step("async_reset", 7, 0, 4'b0010, 7, 1'b0, 1'b0, 4);
        reset = 1'b0;

        // I-type with sign-extended immediate
        @(negedge clock);
        drive(2'b11, 3'b000, 7'b0000000, 5'd3, 5'd0, 1'b1, 12'hFFF, 1'b0, '0);
        check_step("addi_neg1", 3, 0, 4'b0010, 2, 1'b0, 1'b0, 4);
        drive(2'b11, 3'b000, 7'b0000000, 5'd3, 5'd0, 1'b1, 12'h003, 1'b0, '0);
        check_step("addi_pos3", 3, 0, 4'b0010, 6, 1'b0, 1'b0, 4);

        // beq next-PC selection from pc = 10
        drive(2'b01, 3'b000, 7'b0000000, 5'd4, 5'd4, 1'b0, 12'h008, 1'b1, 10);
        check_step("beq_taken", 4, 4, 4'b0110, 0, 1'b1, 1'b0, 26);
        drive(2'b01, 3'b000, 7'b0000000, 5'd4, 5'd4, 1'b0, 12'hFFE, 1'b1, 10);
        check_step("beq_back", 4, 4, 4'b0110, 0, 1'b1, 1'b0, 6);
        drive(2'b01, 3'b000, 7'b0000000, 5'd4, 5'd5, 1'b0, 12'h008, 1'b1, 10);
        check_step("beq_not_equal", 4, 5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 14);
        drive(2'b01, 3'b000, 7'b0000000, 5'd4, 5'd4, 1'b0, 12'h008, 1'b0, 10);
        check_step("no_branch", 4, 4, 4'b0110, 0, 1'b1, 1'b0, 14);
        drive(2'b01, 3'b000, 7'b0000000, 5'd4, 5'd4, 1'b0, 12'h800, 1'b1, 10);
        check_step("beq_wrap", 4, 4, 4'b0110, 0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_F00A);

        // Build x9 = 2^63 - 1: x9 = 1, doubled 63 times, then minus 1
        do_write(5'd9, 2'b10, 5'd1, 5'd0);
        for (int k = 0; k < 63; k++) begin
            do_write(5'd9, 2'b10, 5'd9, 5'd9);
        end
        do_write(5'd9, 2'b01, 5'd9, 5'd1);

        @(negedge clock);
        drive(2'b10, 3'b000, 7'b0000000, 5'd9, 5'd1, 1'b0, 12'h000, 1'b0, '0);
        check_step("add_overflow", c_max_pos, 1, 4'b0010, c_min_neg, 1'b0, 1'b1, 4);
        drive(2'b01, 3'b000, 7'b0000000, 5'd0, 5'd9, 1'b0, 12'h000, 1'b0, '0);
        check_step("sub_no_overflow", 0, c_max_pos, 4'b0110, 64'h8000_0000_0000_0001,
                   1'b0, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #50000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
